seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the ALU's multiplexed 7-segment display driver.
- Samples the scanned anode/segment lines, waits for each digit to settle, and decodes each segment pattern back to its BCD value per position.
- Reconstructs the decimal result from positions 0/1; presents positions 2/3 as the displayed operands.
- Used as a loopback checker and board self-test monitor sitting beside the display driver.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical one-hot samples needed before a capture (min 2)
TIMEOUT_CYCLES, 1000000, clk1 cycles without a capture before all positions are marked stale
TO_W, 20, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk1  input  1  system clock, single clock domain
rst  input  1  asynchronous, active-high reset
an  input  4  anode select, active-high one-hot: 1000=pos0, 0100=pos1, 0010=pos2, 0001=pos3
seg  input  8  segment lines, active-low; bits [7:1]=a..g, bit0=dp (ignored)
digits  output  16  decoded values {pos3,pos2,pos1,pos0}, 4 bits each; 4'hF = blank or error
valid  output  4  per-position: holds a good decoded digit
err  output  4  per-position: last pattern was not a legal code
upd  output  1  one-cycle pulse on every capture
upd_pos  output  2  position of the most recent capture
frame_done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse
result_dec  output  7  digits[7:4]*10 + digits[3:0] when valid[1:0]==2'b11, else 0
stale  output  1  timeout flag

Behaviour:
- Reset (async, rst=1): all outputs 0, except digits = 16'hFFFF. Synchronizer, stability counter, seen-mask and timeout counter are cleared. Capture can resume no earlier than STABLE_CYCLES+2 cycles after rst deasserts.
- Input sync: an and seg each pass through 2 flops, giving an_s/seg_s.
- Latency: 2 cycles sync plus STABLE_CYCLES samples, then the capture registers update on the next edge.
- Stability counter:
  - Increments while an_s is one-hot and {an_s, seg_s[7:1]} equals the previous cycle's value.
  - Resets to 0 on any change or on a non-one-hot an_s (0000 or multi-hot).
  - Saturates once it reaches STABLE_CYCLES-1.
  - Capture fires exactly once per dwell, on the cycle the counter first reaches STABLE_CYCLES-1. No re-capture until the inputs change.
- Decode table on seg[7:1]:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 1111111 = blank: digit F, valid 0, err 0.
  - Any other pattern: digit F, valid 0, err 1.
  - Legal code: digit = value, valid 1, err 0.
- Capture writes digit/valid/err of the selected position only; other positions hold. upd=1 and upd_pos=position for that cycle.
- Seen mask:
  - Each capture sets the bit for its position.
  - When a capture makes the mask 1111, frame_done=1 in that same cycle and the mask clears to 0000; that capture is not carried into the next frame.
  - Repeated captures of one position do not advance the mask.
- result_dec is registered. It updates the cycle after any capture touching pos0/pos1. Range 0..99, 7-bit unsigned.
- Timeout:
  - The counter increments every cycle and clears on capture.
  - On reaching TIMEOUT_CYCLES: valid=0000, stale=1, seen mask cleared, counter holds. digits and err hold.
  - The next capture clears stale.
  - Capture and timeout in the same cycle: capture wins; stale stays 0 and the counter clears.
- rst mid-dwell abandons the partial count; no capture is produced from pre-reset samples.

Test Plan:
- Reset: assert rst mid-scan -> immediately digits=FFFF, valid=0, upd=0, stale=0; after release, no upd before STABLE_CYCLES+2 cycles.
- Dwell: drive an=1000, seg=00001101 (3) for 10 cycles -> one upd pulse with upd_pos=0, digits[3:0]=3, valid[0]=1; exactly one pulse for the dwell.
- Glitch: hold an=0100, seg=10011111 for only STABLE_CYCLES-1 cycles, then change to an=0110 -> no capture, valid unchanged.
- Frame: scan pos0=5 (01001001), pos1=1 (10011111), pos2=7, pos3=9 -> frame_done pulses with the pos3 capture, digits=16'h9715, result_dec=15.
- Illegal/blank: pos2 seg=11111111 -> valid[2]=0, err[2]=0, digit F; pos2 seg=01010101 -> err[2]=1, digit F.
- Timeout: with TIMEOUT_CYCLES=50, stop scanning after a full frame -> at cycle 50 valid=0000, stale=1; next good capture clears stale and sets only that position's valid bit.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// Decodes a scanned, multiplexed 7-segment display back into per-position BCD digits.
// Latency: 2 sync flops + STABLE_CYCLES identical samples, then capture registers load.
// Backpressure: none; this passive monitor never stalls and drops nothing it can observe.
//
// Ports:
//   clk1, rst           single clock, asynchronous active-high reset
//   an[3:0]             one-hot anode select (1000=pos0 .. 0001=pos3)
//   seg[7:0]            active-low segments, [7:1]=a..g, [0]=dp (ignored)
//   digits[15:0]        {pos3,pos2,pos1,pos0}; 4'hF = blank or illegal
//   valid/err[3:0]      per-position good digit / last pattern illegal
//   upd, upd_pos        capture pulse and its position
//   frame_done          pulse when all four positions have been captured
//   result_dec[6:0]     pos1*10 + pos0 when both are valid, else 0
//   stale               no capture for TIMEOUT_CYCLES
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        upd,
    output logic [1:0]  upd_pos,
    output logic        frame_done,
    output logic [6:0]  result_dec,
    output logic        stale
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // Decimal point carries no digit information.
    logic unused_dp;
    assign unused_dp = seg[0];

    // Returns {digit[3:0], valid, err}.
    function automatic logic [5:0] decode7(input logic [6:0] s);
        case (s)
            7'b0000001: decode7 = {4'd0, 2'b10};
            7'b1001111: decode7 = {4'd1, 2'b10};
            7'b0010010: decode7 = {4'd2, 2'b10};
            7'b0000110: decode7 = {4'd3, 2'b10};
            7'b1001100: decode7 = {4'd4, 2'b10};
            7'b0100100: decode7 = {4'd5, 2'b10};
            7'b0100000: decode7 = {4'd6, 2'b10};
            7'b0001111: decode7 = {4'd7, 2'b10};
            7'b0000000: decode7 = {4'd8, 2'b10};
            7'b0000100: decode7 = {4'd9, 2'b10};
            7'b1111111: decode7 = {4'hF, 2'b00};
            default:    decode7 = {4'hF, 2'b01};
        endcase
    endfunction

    logic [3:0]       an_m_q, an_s_q;
    logic [6:0]       seg_m_q, seg_s_q;
    logic [10:0]      prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       err_q, err_d;
    logic [3:0]       seen_q, seen_d;
    logic             upd_q, frame_q, frame_d, stale_q, stale_d;
    logic [1:0]       upd_pos_q, upd_pos_d;
    logic [6:0]       result_q, result_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic        onehot, stable, cap;
    logic [1:0]  pos;
    logic [5:0]  dec;
    logic [3:0]  seen_set;

    assign onehot = (an_s_q != 4'd0) && ((an_s_q & (an_s_q - 4'd1)) == 4'd0);
    assign stable = onehot && ({an_s_q, seg_s_q} == prev_q);
    // Fires only on the transition into saturation, so one capture per dwell.
    assign cap    = stable && (cnt_q == CNT_ARM);
    assign dec    = decode7(seg_s_q);

    always_comb begin
        case (an_s_q)
            4'b1000: pos = 2'd0;
            4'b0100: pos = 2'd1;
            4'b0010: pos = 2'd2;
            default: pos = 2'd3;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (stable) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        err_d     = err_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        stale_d   = stale_q;
        upd_pos_d = upd_pos_q;
        to_d      = to_q;
        seen_set  = seen_q | (4'b0001 << pos);
        if (cap) begin
            digits_d[{pos, 2'b00} +: 4] = dec[5:2];
            valid_d[pos] = dec[1];
            err_d[pos]   = dec[0];
            upd_pos_d    = pos;
            stale_d      = 1'b0;
            to_d         = '0;
            if (seen_set == 4'b1111) begin
                frame_d = 1'b1;
                seen_d  = 4'b0000;
            end else begin
                seen_d  = seen_set;
            end
        end else if (to_q == TO_LAST) begin
            valid_d = 4'b0000;
            stale_d = 1'b1;
            seen_d  = 4'b0000;
            to_d    = TO_MAX;
        end else if (to_q != TO_MAX) begin
            to_d    = to_q + 1'b1;
        end
    end

    // Tracks the registered digits, so it lags a pos0/pos1 capture by one cycle.
    always_comb begin
        result_d = 7'd0;
        if (valid_q[1:0] == 2'b11) begin
            result_d = {digits_q[7:4], 3'b000} + {2'b00, digits_q[7:4], 1'b0}
                     + {3'b000, digits_q[3:0]};
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            an_m_q    <= '0;
            an_s_q    <= '0;
            seg_m_q   <= '0;
            seg_s_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            digits_q  <= 16'hFFFF;
            valid_q   <= '0;
            err_q     <= '0;
            seen_q    <= '0;
            upd_q     <= 1'b0;
            upd_pos_q <= '0;
            frame_q   <= 1'b0;
            result_q  <= '0;
            stale_q   <= 1'b0;
            to_q      <= '0;
        end else begin
            an_m_q    <= an;
            an_s_q    <= an_m_q;
            seg_m_q   <= seg[7:1];
            seg_s_q   <= seg_m_q;
            prev_q    <= {an_s_q, seg_s_q};
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            upd_q     <= cap;
            upd_pos_q <= upd_pos_d;
            frame_q   <= frame_d;
            result_q  <= result_d;
            stale_q   <= stale_d;
            to_q      <= to_d;
        end
    end

    assign digits     = digits_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign upd        = upd_q;
    assign upd_pos    = upd_pos_q;
    assign frame_done = frame_q;
    assign result_dec = result_q;
    assign stale      = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed table-driven bench for the 7-segment scan decoder (STABLE=4, TIMEOUT=50).
// Latency: capture pulse observed on the 6th falling edge after a new stable input.
// Backpressure: none; inputs are driven on falling edges, outputs sampled on falling edges.
module tb_seven_seg_scan_decoder;

    logic        clk1 = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid, err;
    logic        upd, frame_done, stale;
    logic [1:0]  upd_pos;
    logic [6:0]  result_dec;

    seven_seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(50),
        .TO_W          (20)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .valid     (valid),
        .err       (err),
        .upd       (upd),
        .upd_pos   (upd_pos),
        .frame_done(frame_done),
        .result_dec(result_dec),
        .stale     (stale)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          hold;
        int          n_upd;
        int          pos;
        int          n_frm;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic [3:0]  er;
        int          res;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic [3:0] a, input logic [7:0] s, input int h,
                                input int nu, input int p, input int nf,
                                input logic [15:0] d, input logic [3:0] v,
                                input logic [3:0] e, input int r);
        vec_t t;
        t.an = a; t.seg = s; t.hold = h; t.n_upd = nu; t.pos = p; t.n_frm = nf;
        t.dig = d; t.vld = v; t.er = e; t.res = r;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        int nu, nf, lp;
        nu = 0; nf = 0; lp = -1;
        an  = v.an;
        seg = v.seg;
        for (int c = 0; c < v.hold; c++) begin
            @(negedge clk1);
            if (upd) begin
                nu++;
                lp = int'(upd_pos);
            end
            if (frame_done) nf++;
        end
        check({tag, " upd count"}, nu, v.n_upd);
        if (v.n_upd > 0) check({tag, " upd_pos"}, lp, v.pos);
        check({tag, " frame count"}, nf, v.n_frm);
        check({tag, " digits"}, int'(digits), int'(v.dig));
        check({tag, " valid"}, int'(valid), int'(v.vld));
        check({tag, " err"}, int'(err), int'(v.er));
        check({tag, " result_dec"}, int'(result_dec), v.res);
        check({tag, " stale"}, int'(stale), 0);
    endtask

    // Holds current inputs after reset release and checks capture timing.
    task automatic post_reset(input string tag);
        int first, nu;
        first = -1; nu = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk1);
            if (upd) begin
                nu++;
                if (first < 0) first = c;
            end
        end
        check({tag, " first upd cycle"}, first, 6);
        check({tag, " upd count"}, nu, 1);
    endtask

    vec_t tab[18];
    vec_t post[4];

    initial begin
        tab[0]  = mk(4'b1000, 8'h0C, 10, 0, 0, 0, 16'hFFF3, 4'b0001, 4'b0000, 0);
        tab[1]  = mk(4'b0100, 8'h9F,  3, 0, 0, 0, 16'hFFF3, 4'b0001, 4'b0000, 0);
        tab[2]  = mk(4'b0110, 8'h9F, 10, 0, 0, 0, 16'hFFF3, 4'b0001, 4'b0000, 0);
        tab[3]  = mk(4'b0000, 8'h9F,  4, 0, 0, 0, 16'hFFF3, 4'b0001, 4'b0000, 0);
        tab[4]  = mk(4'b1000, 8'h49, 10, 1, 0, 0, 16'hFFF5, 4'b0001, 4'b0000, 0);
        tab[5]  = mk(4'b0100, 8'h9F, 10, 1, 1, 0, 16'hFF15, 4'b0011, 4'b0000, 15);
        tab[6]  = mk(4'b0010, 8'h1F, 10, 1, 2, 0, 16'hF715, 4'b0111, 4'b0000, 15);
        tab[7]  = mk(4'b0001, 8'h09, 10, 1, 3, 1, 16'h9715, 4'b1111, 4'b0000, 15);
        tab[8]  = mk(4'b0100, 8'h25, 10, 1, 1, 0, 16'h9725, 4'b1111, 4'b0000, 25);
        tab[9]  = mk(4'b0010, 8'hFF, 10, 1, 2, 0, 16'h9F25, 4'b1011, 4'b0000, 25);
        tab[10] = mk(4'b0010, 8'h55, 10, 1, 2, 0, 16'h9F25, 4'b1011, 4'b0100, 25);
        tab[11] = mk(4'b1000, 8'h01, 10, 1, 0, 0, 16'h9F28, 4'b1011, 4'b0100, 28);
        tab[12] = mk(4'b0001, 8'h03, 10, 1, 3, 1, 16'h0F28, 4'b1011, 4'b0100, 28);
        tab[13] = mk(4'b0010, 8'h41, 10, 1, 2, 0, 16'h0628, 4'b1111, 4'b0000, 28);
        tab[14] = mk(4'b0001, 8'h99, 10, 1, 3, 0, 16'h4628, 4'b1111, 4'b0000, 28);
        tab[15] = mk(4'b0001, 8'h09, 10, 1, 3, 0, 16'h9628, 4'b1111, 4'b0000, 28);
        tab[16] = mk(4'b1000, 8'h0D, 10, 1, 0, 0, 16'h9623, 4'b1111, 4'b0000, 23);
        tab[17] = mk(4'b0100, 8'h9F, 10, 1, 1, 1, 16'h9613, 4'b1111, 4'b0000, 13);

        post[0] = mk(4'b0100, 8'h25, 10, 1, 1, 0, 16'h9625, 4'b0010, 4'b0000, 0);
        post[1] = mk(4'b0010, 8'h1F, 10, 1, 2, 0, 16'h9725, 4'b0110, 4'b0000, 0);
        post[2] = mk(4'b0001, 8'h09, 10, 1, 3, 0, 16'h9725, 4'b1110, 4'b0000, 0);
        post[3] = mk(4'b1000, 8'h0D, 10, 1, 0, 1, 16'h9723, 4'b1111, 4'b0000, 23);

        // Reset state, then first dwell on pos0 = 3.
        rst = 1'b1;
        an  = 4'b1000;
        seg = 8'h0D;
        @(negedge clk1);
        check("reset digits", int'(digits), 16'hFFFF);
        check("reset valid", int'(valid), 0);
        check("reset err", int'(err), 0);
        check("reset upd", int'(upd), 0);
        check("reset upd_pos", int'(upd_pos), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset result_dec", int'(result_dec), 0);
        check("reset stale", int'(stale), 0);
        rst = 1'b0;
        post_reset("dwell");
        check("dwell digits", int'(digits), 16'hFFF3);
        check("dwell valid", int'(valid), 4'b0001);

        for (int i = 0; i < 18; i++) apply($sformatf("v%0d", i), tab[i]);

        // Timeout: capture pos0=5, then stop producing new captures.
        apply("to_cap", mk(4'b1000, 8'h49, 7, 1, 0, 0, 16'h9615, 4'b1111, 4'b0000, 15));
        repeat (48) @(negedge clk1);
        check("timeout-1 stale", int'(stale), 0);
        check("timeout-1 valid", int'(valid), 4'b1111);
        @(negedge clk1);
        check("timeout stale", int'(stale), 1);
        check("timeout valid", int'(valid), 0);
        check("timeout digits", int'(digits), 16'h9615);
        check("timeout err", int'(err), 0);
        repeat (2) @(negedge clk1);
        check("timeout result_dec", int'(result_dec), 0);
        check("timeout stale hold", int'(stale), 1);

        // Seen mask was cleared by the timeout: frame needs all four again.
        for (int i = 0; i < 4; i++) apply($sformatf("p%0d", i), post[i]);

        // Reset in the middle of a dwell.
        an  = 4'b0010;
        seg = 8'h1F;
        repeat (3) @(negedge clk1);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst digits", int'(digits), 16'hFFFF);
        check("mid rst valid", int'(valid), 0);
        check("mid rst upd", int'(upd), 0);
        check("mid rst stale", int'(stale), 0);
        check("mid rst result_dec", int'(result_dec), 0);
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        post_reset("mid rst");
        check("mid rst upd_pos", int'(upd_pos), 2);
        check("mid rst cap digits", int'(digits), 16'hF7FF);
        check("mid rst cap valid", int'(valid), 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
